// File: rtl/mul_pkg.sv
// Shared types for the repeated-addition multiplier: controller states and default width.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mul_repeated_add_if.sv
// Operand/result bus of the multiplier: start request, serial operand input, product and done.
interface mul_repeated_add_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic                 start;
  logic [WIDTH-1:0]     data_in;
  logic [2*WIDTH-1:0]   product;
  logic                 done;

  modport master (
    output start,
    output data_in,
    input  product,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    output product,
    output done
  );

endinterface

// File: rtl/mul_datapath.sv
// Datapath: multiplicand A, down-counter B and accumulator P with adder, decrementer and eqz.
// MUL_EARLY_EXIT_EN: a zero multiplicand also raises eqz.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 ld_a,
  input  logic                 ld_b,
  input  logic                 ld_p,
  input  logic                 clr_p,
  input  logic                 dec_b,
  output logic                 eqz,
  output logic [2*WIDTH-1:0]   p
);

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] sum;

  assign sum = p + {{WIDTH{1'b0}}, a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
    end else if (ld_a) begin
      a <= data_in;
    end
  end

  // The controller only asserts dec_b while eqz is low, so B never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b <= '0;
    end else if (ld_b) begin
      b <= data_in;
    end else if (dec_b) begin
      b <= b - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (clr_p) begin
      p <= '0;
    end else if (ld_p) begin
      p <= sum;
    end
  end

`ifdef MUL_EARLY_EXIT_EN
  assign eqz = (b == '0) || (a == '0);
`else
  assign eqz = (b == '0);
`endif

endmodule

// File: rtl/mul_repeated_add.sv
// Repeated-addition unsigned multiplier: FSM controller over mul_datapath, registered done.
// MUL_EARLY_EXIT_EN (see mul_datapath) shortens ADD when the multiplicand is zero.
module mul_repeated_add
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  mul_repeated_add_if.slave  bus
);

  state_t state;
  state_t state_next;
  logic   ld_a;
  logic   ld_b;
  logic   ld_p;
  logic   clr_p;
  logic   dec_b;
  logic   eqz;
  logic   done_q;

  mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (bus.data_in),
    .ld_a    (ld_a),
    .ld_b    (ld_b),
    .ld_p    (ld_p),
    .clr_p   (clr_p),
    .dec_b   (dec_b),
    .eqz     (eqz),
    .p       (bus.product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = LOAD_A;
      LOAD_A:  state_next = LOAD_B;
      LOAD_B:  state_next = ADD;
      ADD:     if (eqz) state_next = DONE;
      DONE:    if (!bus.start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    ld_p  = 1'b0;
    clr_p = 1'b0;
    dec_b = 1'b0;
    unique case (state)
      LOAD_A: ld_a = 1'b1;
      LOAD_B: begin
        ld_b  = 1'b1;
        clr_p = 1'b1;
      end
      ADD: begin
        ld_p  = !eqz;
        dec_b = !eqz;
      end
      default: ;
    endcase
  end

  // done is registered from the next state so it is high exactly while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_next == DONE);
    end
  end

  assign bus.done = done_q;

endmodule

// File: tb/tb_mul_repeated_add.sv
// Directed self-checking bench for mul_repeated_add (latencies follow MUL_EARLY_EXIT_EN).
module tb_mul_repeated_add;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mul_repeated_add_if #(.WIDTH(WIDTH)) bus ();

  mul_repeated_add #(
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one multiply from IDLE; counts edges from leaving IDLE until done rises.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_p, input int exp_lat,
                         input bit hold, input string tag);
    int cycles;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = a;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.data_in = b;
    @(posedge clk);
    cycles = 2;
    #1;
    while (!bus.done && cycles < 200) begin
      @(posedge clk);
      cycles++;
      #1;
    end
    check({tag, "_latency"}, 64'(cycles), 64'(exp_lat));
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_product"}, 64'(bus.product), 64'(exp_p));
    if (!hold) begin
      @(posedge clk);
      #1;
      check({tag, "_idle_done"}, 64'(bus.done), 64'd0);
      check({tag, "_idle_hold"}, 64'(bus.product), 64'(exp_p));
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_product", 64'(bus.product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low: nothing happens.
    repeat (3) @(posedge clk);
    #1;
    check("idle_done", 64'(bus.done), 64'd0);

    run_mul(16'd17, 16'd5, 32'd85, 8, 1'b0, "t1_17x5");
    run_mul(16'd9, 16'd0, 32'd0, 3, 1'b0, "t2_9x0");
`ifdef MUL_EARLY_EXIT_EN
    run_mul(16'd0, 16'd4, 32'd0, 3, 1'b0, "t3_0x4");
`else
    run_mul(16'd0, 16'd4, 32'd0, 7, 1'b0, "t3_0x4");
`endif
    run_mul(16'd65535, 16'd3, 32'h0002_FFFD, 6, 1'b0, "t4_ffffx3");
    run_mul(16'd1, 16'd1, 32'd1, 4, 1'b0, "t4b_1x1");

    // Reset in the middle of ADD (multiplier 10).
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.data_in = 16'd10;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_done", 64'(bus.done), 64'd0);
    check("t5_rst_product", 64'(bus.product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("t5_after_rst_done", 64'(bus.done), 64'd0);
    check("t5_after_rst_product", 64'(bus.product), 64'd0);
    run_mul(16'd6, 16'd7, 32'd42, 10, 1'b0, "t5_6x7");

    // Holding start in DONE must not restart.
    run_mul(16'd7, 16'd2, 32'd14, 5, 1'b1, "t6_7x2");
    repeat (4) @(posedge clk);
    #1;
    check("t6_hold_done", 64'(bus.done), 64'd1);
    check("t6_hold_product", 64'(bus.product), 64'd14);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("t6_drop_done", 64'(bus.done), 64'd0);
    run_mul(16'd12, 16'd3, 32'd36, 6, 1'b0, "t6_12x3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
